// File: rtl/comparator_mc.sv
// Sliced magnitude comparator: walks W-bit slices MSB-first, stops at the first difference; m cycles (1..K) from accept to o_valid.
// Result is held indefinitely under o_ready backpressure; no new request is accepted until it is consumed.
module comparator_mc #(
   parameter int N = 16,
   parameter int W = 4,
   localparam int K  = N / W,
   localparam int IW = (K > 1) ? $clog2(K) : 1,
   localparam int CW = $clog2(K + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_flush,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic          i_s,
   input  logic [N-1:0]  i_a,
   input  logic [N-1:0]  i_b,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [5:0]    o_flags,
   output logic [CW-1:0] o_slices
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, b_q;
   logic          s_q;
   logic [IW-1:0] idx_q;
   logic [CW-1:0] cnt_q;
   logic [5:0]    flags_q;

   logic [N-1:0]  a_sh, b_sh;
   logic [W-1:0]  flip, sa, sb;
   logic          differ, slice_lt, last, accept, step;

   // Flipping the sign bit of the MSB slice turns a signed compare into an unsigned one.
   always_comb begin
      a_sh     = a_q >> (idx_q * W);
      b_sh     = b_q >> (idx_q * W);
      flip     = '0;
      flip[W-1] = s_q && (idx_q == IW'(K - 1));
      sa       = a_sh[W-1:0] ^ flip;
      sb       = b_sh[W-1:0] ^ flip;
      differ   = (sa != sb);
      slice_lt = (sa < sb);
      last     = (idx_q == '0);
   end

   assign accept = (state_q == IDLE) && i_valid && !i_flush;
   assign step   = (state_q == RUN) && !i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid) state_d = RUN;
         RUN:     if (differ || last) state_d = DONE;
         DONE:    if (o_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (i_flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
      end else if (accept) begin
         a_q   <= i_a;
         b_q   <= i_b;
         s_q   <= i_s;
         idx_q <= IW'(K - 1);
         cnt_q <= '0;
      end else if (step) begin
         cnt_q <= cnt_q + CW'(1);
         if (differ)
            flags_q <= {1'b0, 1'b1, slice_lt, slice_lt, !slice_lt, !slice_lt};
         else if (last)
            flags_q <= 6'b100101;
         else
            idx_q <= idx_q - IW'(1);
      end
   end

   assign i_ready  = (state_q == IDLE);
   assign o_valid  = (state_q == DONE);
   assign o_flags  = flags_q;
   assign o_slices = cnt_q;

endmodule

// File: tb/tb_comparator_mc.sv
// Drives four comparators (W = 1, 4, 8, 16; N = 16) in lockstep; directed cases target the W = 4 instance,
// the random sweep checks every instance against a full-width reference compare.
module tb_comparator_mc;

   logic        clk = 1'b0;
   logic        rst_n, i_flush, i_valid, i_s, o_ready;
   logic [15:0] i_a, i_b;
   logic [3:0]  i_ready_w, o_valid_w;
   logic [5:0]  o_flags_w [4];
   logic [4:0]  o_slices_w [4];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int WG  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
      localparam int CWG = $clog2(16 / WG + 1);
      logic [CWG-1:0] sl;
      comparator_mc #(.N(16), .W(WG)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_flush  (i_flush),
         .i_valid  (i_valid),
         .i_ready  (i_ready_w[g]),
         .i_s      (i_s),
         .i_a      (i_a),
         .i_b      (i_b),
         .o_valid  (o_valid_w[g]),
         .o_ready  (o_ready),
         .o_flags  (o_flags_w[g]),
         .o_slices (sl)
      );
      assign o_slices_w[g] = 5'(sl);
   end

   function automatic int w_of(int g);
      return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
   endfunction

   function automatic logic [5:0] ref_flags(logic [15:0] a, logic [15:0] b, logic s);
      logic lt, eq;
      eq = (a == b);
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      return {eq, !eq, lt, lt | eq, !(lt | eq), !lt};
   endfunction

   function automatic int ref_slices(logic [15:0] a, logic [15:0] b, int w);
      logic [15:0] x;
      int msb;
      x = a ^ b;
      if (x == 16'h0) return 16 / w;
      msb = 0;
      for (int i = 0; i < 16; i++) if (x[i]) msb = i;
      return (15 - msb) / w + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(negedge clk);
      i_a = a; i_b = b; i_s = s; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until the W=4 instance shows o_valid.
   task automatic wait_v1(output int lat);
      lat = 0;
      while (!o_valid_w[1] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!o_valid_w[1]) check("timeout_v1", 32'(o_valid_w[1]), 32'd1);
   endtask

   task automatic wait_all();
      int c = 0;
      while (o_valid_w != 4'hF && c < 60) begin
         @(negedge clk);
         c++;
      end
      if (o_valid_w != 4'hF) check("timeout_all", 32'(o_valid_w), 32'hF);
   endtask

   task automatic settle();
      int c = 0;
      @(negedge clk);
      o_ready = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
      while (i_ready_w != 4'hF && c < 60) begin
         @(negedge clk);
         c++;
      end
      if (i_ready_w != 4'hF) check("timeout_settle", 32'(i_ready_w), 32'hF);
      o_ready = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [5:0] flags, input int slices);
      int lat;
      issue(a, b, s);
      wait_v1(lat);
      check({tag, "_lat"}, 32'(lat), 32'(slices));
      check({tag, "_flags"}, 32'(o_flags_w[1]), 32'(flags));
      check({tag, "_slices"}, 32'(o_slices_w[1]), 32'(slices));
      settle();
   endtask

   initial begin
      int lat;
      logic [15:0] a, b;
      logic s;
      int mode;

      rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_s = 1'b0;
      o_ready = 1'b0; i_a = '0; i_b = '0;
      #12;
      check("rst_i_ready", 32'(i_ready_w), 32'hF);
      check("rst_o_valid", 32'(o_valid_w), 32'h0);
      check("rst_flags", 32'(o_flags_w[1]), 32'h0);
      check("rst_slices", 32'(o_slices_w[1]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      directed("equal", 16'h1234, 16'h1234, 1'b0, 6'b100101, 4);
      directed("msb_u", 16'h8000, 16'h0001, 1'b0, 6'b010011, 1);
      directed("msb_s", 16'h8000, 16'h0001, 1'b1, 6'b011100, 1);
      directed("mid_gt", 16'h12F0, 16'h1200, 1'b1, 6'b010011, 3);
      directed("mid_lt", 16'h1200, 16'h12F0, 1'b1, 6'b011100, 3);

      // Backpressure with a waiting request
      issue(16'h8000, 16'h0001, 1'b0);
      wait_v1(lat);
      i_a = 16'h0005; i_b = 16'h0003; i_s = 1'b0; i_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_i_ready", 32'(i_ready_w[1]), 32'd0);
         check("bp_flags", 32'(o_flags_w[1]), 32'(6'b010011));
         check("bp_o_valid", 32'(o_valid_w[1]), 32'd1);
      end
      o_ready = 1'b1;
      @(negedge clk);
      check("bp_idle", 32'(i_ready_w[1]), 32'd1);
      check("bp_released", 32'(o_valid_w[1]), 32'd0);
      o_ready = 1'b0;
      @(negedge clk);
      check("bp_accepted", 32'(i_ready_w[1]), 32'd0);
      i_valid = 1'b0;
      wait_v1(lat);
      check("bp2_lat", 32'(lat), 32'd4);
      check("bp2_flags", 32'(o_flags_w[1]), 32'(6'b010011));
      check("bp2_slices", 32'(o_slices_w[1]), 32'd4);
      settle();

      // Flush in the second RUN cycle
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      @(negedge clk);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      check("flush_i_ready", 32'(i_ready_w[1]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check("flush_no_valid", 32'(o_valid_w[1]), 32'd0);
         @(negedge clk);
      end
      settle();

      // Asynchronous reset while holding a result
      issue(16'h12F0, 16'h1200, 1'b1);
      wait_v1(lat);
      check("pre_rst_valid", 32'(o_valid_w[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_o_valid", 32'(o_valid_w[1]), 32'd0);
      check("arst_flags", 32'(o_flags_w[1]), 32'h0);
      check("arst_i_ready", 32'(i_ready_w[1]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      settle();

      // Random sweep, biased toward late and full-length decisions
      for (int t = 0; t < 3000; t++) begin
         a = 16'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 0)      b = a;
         else if (mode == 1) b = a ^ (16'h1 << $urandom_range(0, 15));
         else                b = 16'($urandom);
         s = 1'($urandom_range(0, 1));
         issue(a, b, s);
         wait_all();
         for (int g = 0; g < 4; g++) begin
            check("rnd_flags", 32'(o_flags_w[g]), 32'(ref_flags(a, b, s)));
            check("rnd_slices", 32'(o_slices_w[g]), 32'(ref_slices(a, b, w_of(g))));
         end
         settle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
